// File: rtl/shift_controller_pkg.sv
// Shared definitions for the iterative shift sequencer: op codes, FSM states, default widths.
package shift_controller_pkg;

    localparam int unsigned WIDTH_DEFAULT   = 32;
    localparam int unsigned SHAMT_W_DEFAULT = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    // Bits needed to encode a per-cycle shift amount in 0..step.
    function automatic int unsigned amt_width(int unsigned step);
        return (step < 2) ? 1 : $clog2(step + 1);
    endfunction

endpackage

// File: rtl/shift_controller_if.sv
// Request/result bundle between the control unit (master) and the shift sequencer (slave).
interface shift_controller_if
    import shift_controller_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) ();

    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   entrada;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   saida;
    logic               busy;
    logic               done;

    modport master (
        output start, op, entrada, shamt,
        input  saida, busy, done
    );

    modport slave (
        input  start, op, entrada, shamt,
        output saida, busy, done
    );

endinterface

// File: rtl/shift_controller_step.sv
// Combinational single shift stage: moves value by 0..STEP positions, sign-filling only for SRA.
module shift_step
    import shift_controller_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned AMT_W = 1
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic [1:0]       op_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] right_zero;
    logic [WIDTH-1:0] vacated;

    always_comb begin
        right_zero = value_i >> amount_i;
        vacated    = ~({WIDTH{1'b1}} >> amount_i);
        unique case (op_i)
            OP_SLL:  value_o = value_i << amount_i;
            OP_SRL:  value_o = right_zero;
            OP_SRA:  value_o = right_zero | (fill_i ? vacated : '0);
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/shift_controller.sv
// Multi-cycle SLL/SRL/SRA sequencer: one narrow shift stage applied until the amount is used up.
module shift_controller
    import shift_controller_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT,
    parameter int unsigned STEP    = 1
) (
    input logic               clock,
    input logic               reset,
    shift_controller_if.slave bus
);

    localparam int unsigned AMT_W = amt_width(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   saida_q, saida_d;

    logic [AMT_W-1:0]   step_amt;
    logic [SHAMT_W-1:0] remaining_after;
    logic [WIDTH-1:0]   step_out;

    shift_step #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) u_step (
        .value_i (work_q),
        .op_i    (op_q),
        .amount_i(step_amt),
        .fill_i  (sign_q),
        .value_o (step_out)
    );

    always_comb begin
        if (remaining_q >= SHAMT_W'(STEP)) begin
            step_amt = AMT_W'(STEP);
        end else begin
            step_amt = AMT_W'(remaining_q);
        end
        remaining_after = remaining_q - SHAMT_W'(step_amt);
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        sign_d      = sign_q;
        saida_d     = saida_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    work_d      = bus.entrada;
                    op_d        = bus.op;
                    remaining_d = bus.shamt;
                    sign_d      = bus.entrada[WIDTH-1];
                    // Zero amount and the reserved op both complete as a pass-through.
                    if (bus.shamt == '0 || bus.op == OP_RSV) begin
                        saida_d = bus.entrada;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d      = step_out;
                remaining_d = remaining_after;
                if (remaining_after == '0) begin
                    saida_d = step_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            op_q        <= '0;
            remaining_q <= '0;
            sign_q      <= 1'b0;
            saida_q     <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            sign_q      <= sign_d;
            saida_q     <= saida_d;
        end
    end

    assign bus.saida = saida_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_controller.sv
// Directed bench for shift_controller: STEP=1 and STEP=4 instances, latency and result checks.
module tb_shift_controller;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    shift_controller_if #(.WIDTH(32), .SHAMT_W(5)) if1 ();
    shift_controller_if #(.WIDTH(32), .SHAMT_W(5)) if4 ();

    shift_controller #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
        .clock(clock),
        .reset(reset),
        .bus  (if1.slave)
    );

    shift_controller #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
        .clock(clock),
        .reset(reset),
        .bus  (if4.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic [1:0] o,
                         input logic [31:0] e, input logic [4:0] sh);
        if (sel == 4) begin
            if4.start = s; if4.op = o; if4.entrada = e; if4.shamt = sh;
        end else begin
            if1.start = s; if1.op = o; if1.entrada = e; if1.shamt = sh;
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 4) ? if4.busy : if1.busy;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 4) ? if4.done : if1.done;
    endfunction

    function automatic logic [31:0] saida_of(input int sel);
        return (sel == 4) ? if4.saida : if1.saida;
    endfunction

    // Accept one op, then scramble the inputs and count busy/done cycles (bounded).
    task automatic run_op(input int sel, input logic [1:0] o, input logic [31:0] e,
                          input logic [4:0] sh, output int busy_n, output int done_n,
                          output int done_at);
        drive(sel, 1'b1, o, e, sh);
        tick();
        drive(sel, 1'b0, 2'b00, 32'hA5A5_5A5A, 5'd7);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        for (int c = 1; c <= 200; c++) begin
            if (!busy_of(sel)) break;
            busy_n++;
            if (done_of(sel)) begin
                done_n++;
                done_at = c;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
        drive(4, 1'b0, 2'b00, 32'h0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (if1.saida !== 32'h0) begin
            n_bad++; $display("FAIL reset_saida got %h want %h", if1.saida, 32'h0);
        end
        n_cmp++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", if1.busy, if1.done);
        end
        n_cmp++;
        if (if4.busy !== 1'b0 || if4.saida !== 32'h0) begin
            n_bad++; $display("FAIL reset_step4 got busy=%b saida=%h want 0 0", if4.busy, if4.saida);
        end
    endtask

    task automatic test_sll_basic();
        int b, d, at;
        run_op(1, 2'b00, 32'h0000_0001, 5'd2, b, d, at);
        n_cmp++;
        if (b !== 3) begin n_bad++; $display("FAIL sll2_busy got %0d want 3", b); end
        n_cmp++;
        if (d !== 1 || at !== 3) begin
            n_bad++; $display("FAIL sll2_done got count=%0d at=%0d want 1 at 3", d, at);
        end
        n_cmp++;
        if (if1.saida !== 32'h0000_0004) begin
            n_bad++; $display("FAIL sll2_saida got %h want %h", if1.saida, 32'h4);
        end
        tick();
        tick();
        n_cmp++;
        if (if1.saida !== 32'h0000_0004 || if1.busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold got saida=%h busy=%b want 00000004 0", if1.saida, if1.busy);
        end
    endtask

    task automatic test_long_shift();
        int b, d, at;
        run_op(1, 2'b10, 32'h8000_0000, 5'd31, b, d, at);
        n_cmp++;
        if (b !== 32 || d !== 1 || at !== 32) begin
            n_bad++; $display("FAIL sra31_timing got busy=%0d done=%0d at=%0d want 32 1 32", b, d, at);
        end
        n_cmp++;
        if (if1.saida !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL sra31_saida got %h want %h", if1.saida, 32'hFFFF_FFFF);
        end
        run_op(1, 2'b01, 32'h8000_0000, 5'd31, b, d, at);
        n_cmp++;
        if (b !== 32 || d !== 1) begin
            n_bad++; $display("FAIL srl31_timing got busy=%0d done=%0d want 32 1", b, d);
        end
        n_cmp++;
        if (if1.saida !== 32'h0000_0001) begin
            n_bad++; $display("FAIL srl31_saida got %h want %h", if1.saida, 32'h1);
        end
    endtask

    task automatic test_passthrough();
        int b, d, at;
        run_op(1, 2'b00, 32'h1234_5678, 5'd0, b, d, at);
        n_cmp++;
        if (b !== 1 || d !== 1 || at !== 1) begin
            n_bad++; $display("FAIL shamt0_timing got busy=%0d done=%0d at=%0d want 1 1 1", b, d, at);
        end
        n_cmp++;
        if (if1.saida !== 32'h1234_5678) begin
            n_bad++; $display("FAIL shamt0_saida got %h want %h", if1.saida, 32'h1234_5678);
        end
        run_op(1, 2'b11, 32'hCAFE_F00D, 5'd9, b, d, at);
        n_cmp++;
        if (b !== 1 || d !== 1 || at !== 1) begin
            n_bad++; $display("FAIL rsv_timing got busy=%0d done=%0d at=%0d want 1 1 1", b, d, at);
        end
        n_cmp++;
        if (if1.saida !== 32'hCAFE_F00D) begin
            n_bad++; $display("FAIL rsv_saida got %h want %h", if1.saida, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_start_ignored();
        int b, d;
        b = 0;
        d = 0;
        drive(1, 1'b1, 2'b00, 32'h0000_0001, 5'd4);
        tick();
        for (int c = 1; c <= 100; c++) begin
            if (!if1.busy) break;
            b++;
            if (if1.done) d++;
            // Hold a competing request through SHIFT and DONE.
            drive(1, 1'b1, 2'b01, 32'hFFFF_FFFF, 5'd1);
            tick();
        end
        drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
        n_cmp++;
        if (b !== 5 || d !== 1) begin
            n_bad++; $display("FAIL ignore_timing got busy=%0d done=%0d want 5 1", b, d);
        end
        n_cmp++;
        if (if1.saida !== 32'h0000_0010) begin
            n_bad++; $display("FAIL ignore_saida got %h want %h", if1.saida, 32'h10);
        end
        tick();
        n_cmp++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.saida !== 32'h0000_0010) begin
            n_bad++;
            $display("FAIL ignore_not_queued got busy=%b done=%b saida=%h want 0 0 00000010",
                     if1.busy, if1.done, if1.saida);
        end
    endtask

    task automatic test_reset_abort();
        int b, d, at, stray;
        drive(1, 1'b1, 2'b10, 32'h8000_0000, 5'd10);
        tick();
        drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (if1.saida !== 32'h0 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reset got saida=%h busy=%b done=%b want 0 0 0",
                     if1.saida, if1.busy, if1.done);
        end
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            if (if1.done || if1.busy) stray++;
            tick();
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL abort_quiet got %0d active cycles want 0", stray); end
        run_op(1, 2'b00, 32'h0000_0003, 5'd1, b, d, at);
        n_cmp++;
        if (b !== 2 || d !== 1 || if1.saida !== 32'h0000_0006) begin
            n_bad++;
            $display("FAIL after_abort got busy=%0d done=%0d saida=%h want 2 1 00000006", b, d, if1.saida);
        end
    endtask

    task automatic test_step4();
        int b, d, at;
        run_op(4, 2'b01, 32'h0000_00F0, 5'd6, b, d, at);
        n_cmp++;
        if (b !== 3 || d !== 1 || at !== 3) begin
            n_bad++; $display("FAIL step4_srl_timing got busy=%0d done=%0d at=%0d want 3 1 3", b, d, at);
        end
        n_cmp++;
        if (if4.saida !== 32'h0000_0003) begin
            n_bad++; $display("FAIL step4_srl_saida got %h want %h", if4.saida, 32'h3);
        end
        run_op(4, 2'b10, 32'h8000_0000, 5'd5, b, d, at);
        n_cmp++;
        if (b !== 3 || if4.saida !== 32'hFC00_0000) begin
            n_bad++; $display("FAIL step4_sra got busy=%0d saida=%h want 3 fc000000", b, if4.saida);
        end
        run_op(4, 2'b00, 32'h0000_0001, 5'd31, b, d, at);
        n_cmp++;
        if (b !== 9 || if4.saida !== 32'h8000_0000) begin
            n_bad++; $display("FAIL step4_sll31 got busy=%0d saida=%h want 9 80000000", b, if4.saida);
        end
    endtask

    initial begin
        test_reset();
        test_sll_basic();
        test_long_shift();
        test_passthrough();
        test_start_ignored();
        test_reset_abort();
        test_step4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
